// File: rtl/can_frame_node.sv
// rtl/can_frame_node.sv - CAN 2.0 transmit node: framing, bit stuffing, CRC-15, arbitration and ACK check
// One bus bit is sampled and driven per bit_tick; errors only release the bus, no error frames.
module can_frame_node #(
   parameter int ID_WIDTH  = 11,
   parameter int MAX_DLC   = 8,
   parameter int IDLE_BITS = 11
) (
   input  logic                 can_clk,
   input  logic                 reset,
   input  logic                 bit_tick,
   input  logic                 can_rx,
   output logic                 can_tx,
   input  logic                 tx_req,
   input  logic [ID_WIDTH-1:0]  tx_id,
   input  logic [3:0]           tx_dlc,
   input  logic [8*MAX_DLC-1:0] tx_data,
   output logic                 tx_accept,
   output logic                 tx_done,
   output logic                 arb_lost,
   output logic                 tx_err,
   output logic                 busy
);
   localparam int HDR = (ID_WIDTH == 29) ? 39 : 19;
   localparam int DW  = 8 * MAX_DLC;
   localparam int FW  = HDR + DW;
   localparam int CW  = $clog2(IDLE_BITS + 1);
   localparam logic [7:0] ARB_LAST = (ID_WIDTH == 29) ? 8'd32 : 8'd13;

   typedef enum logic [2:0] {
      ST_INTEGRATE, ST_IDLE, ST_SEND, ST_CRC_DEL,
      ST_ACK_SLOT, ST_ACK_DEL, ST_EOF, ST_RECOVER
   } state_t;

   state_t          state_q, state_d;
   logic            can_tx_q, can_tx_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic [3:0]      dlc_q, dlc_d;
   logic [14:0]     crc_q, crc_d;
   logic [7:0]      idx_q, idx_d;
   logic            stuff_q, stuff_d;
   logic            last_q, last_d;
   logic [2:0]      run_q, run_d;
   logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
   logic [2:0]      eof_cnt_q, eof_cnt_d;
   logic            busy_q, busy_d;
   logic            tx_accept_q, tx_accept_d;
   logic            tx_done_q, tx_done_d;
   logic            arb_lost_q, arb_lost_d;
   logic            tx_err_q, tx_err_d;

   logic [HDR-1:0]  hdr_bits;
   logic [DW-1:0]   data_bits;
   logic [3:0]      nbytes;
   logic [7:0]      data_end;
   logic [7:0]      crc_last;
   logic            nb;
   logic            fail;

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic [14:0] r;
      r = {c[13:0], 1'b0};
      if (b ^ c[14]) r = r ^ 15'h4599;
      return r;
   endfunction

   generate
      if (ID_WIDTH == 29) begin : g_ext
         assign hdr_bits = {1'b0, tx_id[28:18], 2'b11, tx_id[17:0], 3'b000, tx_dlc};
      end else begin : g_std
         assign hdr_bits = {1'b0, tx_id[10:0], 3'b000, tx_dlc};
      end
   endgenerate

   // Byte 0 goes first on the wire, so it lands in the top byte of the shift image.
   always_comb begin
      data_bits = '0;
      for (int i = 0; i < MAX_DLC; i++) begin
         data_bits[8*(MAX_DLC-1-i) +: 8] = tx_data[8*i +: 8];
      end
   end

   assign nbytes   = (dlc_q > 4'(MAX_DLC)) ? 4'(MAX_DLC) : dlc_q;
   assign data_end = 8'(HDR) + {1'b0, nbytes, 3'b000};
   assign crc_last = data_end + 8'd14;

   always_comb begin
      state_d     = state_q;
      can_tx_d    = can_tx_q;
      frame_d     = frame_q;
      dlc_d       = dlc_q;
      crc_d       = crc_q;
      idx_d       = idx_q;
      stuff_d     = stuff_q;
      last_d      = last_q;
      run_d       = run_q;
      idle_cnt_d  = idle_cnt_q;
      eof_cnt_d   = eof_cnt_q;
      busy_d      = busy_q;
      tx_accept_d = 1'b0;
      tx_done_d   = 1'b0;
      arb_lost_d  = 1'b0;
      tx_err_d    = 1'b0;
      nb          = 1'b0;
      fail        = 1'b0;
      if (bit_tick) begin
         unique case (state_q)
            ST_INTEGRATE, ST_RECOVER: begin
               can_tx_d = 1'b1;
               if (!can_rx) begin
                  idle_cnt_d = '0;
               end else if (idle_cnt_q == CW'(IDLE_BITS - 1)) begin
                  idle_cnt_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  idle_cnt_d = idle_cnt_q + CW'(1);
               end
            end
            ST_IDLE: begin
               if (!can_rx) begin
                  state_d = ST_INTEGRATE;
               end else if (tx_req) begin
                  frame_d     = {hdr_bits[HDR-2:0], data_bits, 1'b0};
                  dlc_d       = tx_dlc;
                  crc_d       = '0;
                  idx_d       = 8'd0;
                  stuff_d     = 1'b0;
                  last_d      = 1'b0;
                  run_d       = 3'd1;
                  can_tx_d    = 1'b0;
                  busy_d      = 1'b1;
                  tx_accept_d = 1'b1;
                  state_d     = ST_SEND;
               end
            end
            ST_SEND: begin
               if (can_rx != can_tx_q) begin
                  // Dominant overwrite of our recessive bit inside arbitration means a higher-priority node.
                  if (!stuff_q && idx_q != 8'd0 && idx_q <= ARB_LAST && !can_rx) begin
                     arb_lost_d = 1'b1;
                     busy_d     = 1'b0;
                     can_tx_d   = 1'b1;
                     idle_cnt_d = '0;
                     state_d    = ST_INTEGRATE;
                  end else begin
                     fail = 1'b1;
                  end
               end else if (run_q == 3'd5) begin
                  can_tx_d = ~last_q;
                  last_d   = ~last_q;
                  run_d    = 3'd1;
                  stuff_d  = 1'b1;
               end else if (idx_q == crc_last) begin
                  can_tx_d = 1'b1;
                  state_d  = ST_CRC_DEL;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  stuff_d = 1'b0;
                  if (idx_q + 8'd1 < data_end) begin
                     nb      = frame_q[FW-1];
                     frame_d = {frame_q[FW-2:0], 1'b0};
                     crc_d   = crc_step(crc_q, nb);
                  end else begin
                     nb    = crc_q[14];
                     crc_d = {crc_q[13:0], 1'b0};
                  end
                  can_tx_d = nb;
                  run_d    = (nb == last_q) ? run_q + 3'd1 : 3'd1;
                  last_d   = nb;
               end
            end
            ST_CRC_DEL: begin
               if (!can_rx) fail = 1'b1;
               else state_d = ST_ACK_SLOT;
            end
            ST_ACK_SLOT: begin
               if (can_rx) fail = 1'b1;
               else state_d = ST_ACK_DEL;
            end
            ST_ACK_DEL: begin
               if (!can_rx) begin
                  fail = 1'b1;
               end else begin
                  eof_cnt_d = 3'd0;
                  state_d   = ST_EOF;
               end
            end
            ST_EOF: begin
               if (!can_rx) begin
                  fail = 1'b1;
               end else if (eof_cnt_q == 3'd6) begin
                  tx_done_d  = 1'b1;
                  busy_d     = 1'b0;
                  idle_cnt_d = '0;
                  state_d    = ST_INTEGRATE;
               end else begin
                  eof_cnt_d = eof_cnt_q + 3'd1;
               end
            end
            default: state_d = ST_INTEGRATE;
         endcase
         if (fail) begin
            tx_err_d   = 1'b1;
            busy_d     = 1'b0;
            can_tx_d   = 1'b1;
            idle_cnt_d = '0;
            state_d    = ST_RECOVER;
         end
      end
   end

   always_ff @(posedge can_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_INTEGRATE;
         can_tx_q    <= 1'b1;
         frame_q     <= '0;
         dlc_q       <= '0;
         crc_q       <= '0;
         idx_q       <= '0;
         stuff_q     <= 1'b0;
         last_q      <= 1'b0;
         run_q       <= '0;
         idle_cnt_q  <= '0;
         eof_cnt_q   <= '0;
         busy_q      <= 1'b0;
         tx_accept_q <= 1'b0;
         tx_done_q   <= 1'b0;
         arb_lost_q  <= 1'b0;
         tx_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         can_tx_q    <= can_tx_d;
         frame_q     <= frame_d;
         dlc_q       <= dlc_d;
         crc_q       <= crc_d;
         idx_q       <= idx_d;
         stuff_q     <= stuff_d;
         last_q      <= last_d;
         run_q       <= run_d;
         idle_cnt_q  <= idle_cnt_d;
         eof_cnt_q   <= eof_cnt_d;
         busy_q      <= busy_d;
         tx_accept_q <= tx_accept_d;
         tx_done_q   <= tx_done_d;
         arb_lost_q  <= arb_lost_d;
         tx_err_q    <= tx_err_d;
      end
   end

   assign can_tx    = can_tx_q;
   assign tx_accept = tx_accept_q;
   assign tx_done   = tx_done_q;
   assign arb_lost  = arb_lost_q;
   assign tx_err    = tx_err_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_can_frame_node.sv
// tb/tb_can_frame_node.sv - randomized self-checking bench for can_frame_node
// Reference frames are built field by field, CRC by polynomial long division, then stuffed.
module tb_can_frame_node;
   logic        can_clk = 1'b0;
   logic        reset = 1'b0;
   logic        bit_tick = 1'b0;
   logic        can_rx = 1'b1;
   logic        can_tx;
   logic        tx_req = 1'b0;
   logic [10:0] tx_id = '0;
   logic [3:0]  tx_dlc = '0;
   logic [63:0] tx_data = '0;
   logic        tx_accept, tx_done, arb_lost, tx_err, busy;

   int n_tests = 0;
   int n_fail = 0;
   int idle_pulse = 0;
   int idle_hold = 0;
   logic s_tx, s_acc, s_done, s_lost, s_err, s_busy;

   bit m_bits[300];
   bit m_u[300];
   int m_n, m_nu;
   bit exp_bits[300];
   bit oth_bits[300];
   bit u_bits[300];
   bit cap[300];
   int exp_n, exp_nu, oth_n;

   can_frame_node dut (
      .can_clk(can_clk), .reset(reset), .bit_tick(bit_tick), .can_rx(can_rx), .can_tx(can_tx),
      .tx_req(tx_req), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
      .tx_accept(tx_accept), .tx_done(tx_done), .arb_lost(arb_lost), .tx_err(tx_err), .busy(busy)
   );

   always #5 can_clk = ~can_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   task automatic build_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
      bit w[300];
      logic [15:0] g;
      int nu, nd, n, cnt;
      bit last, b;
      g = 16'hC599;
      nu = 0;
      m_u[nu] = 1'b0; nu++;
      for (int i = 10; i >= 0; i--) begin m_u[nu] = id[i]; nu++; end
      for (int i = 0; i < 3; i++) begin m_u[nu] = 1'b0; nu++; end
      for (int i = 3; i >= 0; i--) begin m_u[nu] = dlc[i]; nu++; end
      nd = (dlc > 4'd8) ? 8 : int'(dlc);
      for (int by = 0; by < nd; by++)
         for (int k = 7; k >= 0; k--) begin m_u[nu] = data[8*by+k]; nu++; end
      for (int i = 0; i < nu + 15; i++) w[i] = (i < nu) ? m_u[i] : 1'b0;
      for (int i = 0; i < nu; i++)
         if (w[i]) for (int k = 0; k < 16; k++) w[i+k] = w[i+k] ^ g[15-k];
      for (int k = 0; k < 15; k++) m_u[nu+k] = w[nu+k];
      nu = nu + 15;
      n = 0; cnt = 0; last = 1'b0;
      for (int i = 0; i < nu; i++) begin
         b = m_u[i];
         m_bits[n] = b; n++;
         if (cnt > 0 && b == last) cnt++;
         else begin cnt = 1; last = b; end
         if (cnt == 5) begin m_bits[n] = !b; n++; last = !b; cnt = 1; end
      end
      for (int i = 0; i < 10; i++) begin m_bits[n] = 1'b1; n++; end
      m_n = n;
      m_nu = nu;
   endtask

   task automatic tick(input logic rx);
      int gap;
      can_rx = rx;
      bit_tick = 1'b1;
      @(posedge can_clk); #1;
      bit_tick = 1'b0;
      s_tx = can_tx; s_acc = tx_accept; s_done = tx_done;
      s_lost = arb_lost; s_err = tx_err; s_busy = busy;
      gap = int'($urandom_range(2, 0));
      for (int i = 0; i < gap; i++) begin
         can_rx = 1'($urandom_range(1, 0));
         @(posedge can_clk); #1;
         if (tx_accept || tx_done || arb_lost || tx_err) idle_pulse++;
         if (can_tx !== s_tx) idle_hold++;
      end
   endtask

   task automatic destuff_check(input int nbits);
      int o, run, bad;
      bit prev, skip;
      o = 0; run = 0; bad = 0; prev = 1'b0; skip = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (skip) begin
            if (cap[i] == prev) bad++;
            prev = cap[i]; run = 1; skip = 1'b0;
         end else begin
            if (o < exp_nu && cap[i] != u_bits[o]) bad++;
            o++;
            if (run > 0 && cap[i] == prev) run++;
            else run = 1;
            prev = cap[i];
            if (run == 5) skip = 1'b1;
         end
      end
      check_eq("destuffed_len", o, exp_nu);
      check_eq("destuffed_bits_bad", bad, 0);
   endtask

   task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                            input bit ack_on, input bit arb_on, input logic [10:0] oid,
                            input int exp_wait, input int abort_at);
      int w, k, end_kind, end_tick, exp_kind, exp_tick, bad, j, nstuf, lim, extra_acc;
      bit got;
      logic rx;
      build_frame(oid, 4'd0, 64'd0);
      oth_bits = m_bits; oth_n = m_n;
      build_frame(id, dlc, data);
      exp_bits = m_bits; exp_n = m_n; exp_nu = m_nu; u_bits = m_u;
      nstuf = exp_n - 10;
      exp_kind = 1; exp_tick = exp_n;
      if (!ack_on) begin exp_kind = 3; exp_tick = nstuf + 2; end
      if (arb_on) begin
         j = -1;
         for (int i = 0; i < nstuf && j < 0; i++) if (exp_bits[i] && !oth_bits[i]) j = i;
         if (j >= 0) begin exp_kind = 2; exp_tick = j + 1; end
      end
      tx_id = id; tx_dlc = dlc; tx_data = data; tx_req = 1'b1;
      w = 0; got = 1'b0;
      while (!got && w < 40) begin tick(1'b1); w++; got = s_acc; end
      check_eq("accept_wait", w, exp_wait);
      if (!got) begin tx_req = 1'b0; return; end
      check_eq("sof_on_accept", s_tx, 0);
      check_eq("busy_on_accept", s_busy, 1);
      tx_req = 1'b0;
      tx_id = 11'($urandom); tx_dlc = 4'($urandom); tx_data = {$urandom, $urandom};
      cap[0] = s_tx; k = 1; end_kind = 0; end_tick = 0; extra_acc = 0;
      while (end_kind == 0 && k < 260) begin
         if (abort_at > 0 && k == abort_at) begin
            #2; reset = 1'b0; #1;
            check_eq("tx_in_reset_cycle", can_tx, 1);
            check_eq("busy_in_reset", busy, 0);
            @(posedge can_clk); #1;
            check_eq("no_pulse_in_reset", {tx_done, tx_err, arb_lost, tx_accept}, 0);
            reset = 1'b1;
            return;
         end
         rx = s_tx;
         if (arb_on && k - 1 < oth_n) rx = rx & oth_bits[k-1];
         if (ack_on && k - 1 == nstuf + 1) rx = 1'b0;
         tick(rx);
         if (s_acc) extra_acc++;
         if (s_done) end_kind = 1;
         else if (s_lost) end_kind = 2;
         else if (s_err) end_kind = 3;
         else cap[k] = s_tx;
         if (end_kind != 0) end_tick = k;
         k++;
      end
      check_eq("end_kind", end_kind, exp_kind);
      check_eq("end_tick", end_tick, exp_tick);
      check_eq("extra_accept", extra_acc, 0);
      lim = (end_tick < exp_tick) ? end_tick : exp_tick;
      bad = 0;
      for (int i = 0; i < lim; i++) if (cap[i] != exp_bits[i]) bad++;
      check_eq("frame_bits_bad", bad, 0);
      if (exp_kind == 1) destuff_check(nstuf);
      check_eq("busy_after_end", s_busy, 0);
      check_eq("tx_after_end", s_tx, 1);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge can_clk);
      #1;
      check_eq("reset_can_tx", can_tx, 1);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_pulses", {tx_accept, tx_done, arb_lost, tx_err}, 0);
      reset = 1'b1;

      run_frame(11'h123, 4'd1, 64'h89, 1'b1, 1'b0, 11'h0, 12, 0);
      run_frame(11'h456, 4'd2, 64'hBEEF, 1'b1, 1'b1, 11'h123, 12, 0);
      run_frame(11'h456, 4'd2, 64'hBEEF, 1'b1, 1'b0, 11'h0, 12, 0);
      run_frame(11'h000, 4'd0, 64'h0, 1'b1, 1'b0, 11'h0, 12, 0);
      check_eq("stuff_bit_after_sof_4zeros", cap[5], 1);
      run_frame(11'h2A5, 4'd3, {$urandom, $urandom}, 1'b0, 1'b0, 11'h0, 12, 0);
      run_frame(11'h7F0, 4'd15, {$urandom, $urandom}, 1'b1, 1'b0, 11'h0, 12, 0);

      tx_req = 1'b0;
      repeat (11) tick(1'b1);
      tx_req = 1'b1;
      tick(1'b0);
      check_eq("foreign_sof_no_accept", s_acc, 0);
      run_frame(11'h0F0, 4'd4, {$urandom, $urandom}, 1'b1, 1'b0, 11'h0, 12, 0);

      run_frame(11'h321, 4'd8, {$urandom, $urandom}, 1'b1, 1'b0, 11'h0, 12, 26);
      run_frame(11'h321, 4'd8, {$urandom, $urandom}, 1'b1, 1'b0, 11'h0, 12, 0);

      for (int r = 0; r < 10; r++)
         run_frame(11'($urandom), 4'($urandom), {$urandom, $urandom},
                   ($urandom_range(3, 0) != 0), 1'b0, 11'h0, 12, 0);

      check_eq("pulses_without_tick", idle_pulse, 0);
      check_eq("tx_hold_without_tick", idle_hold, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/can_frame_node.md
# can_frame_node

Parametrised CAN 2.0 transmit node that serialises a complete data frame onto the bus, one bit per bit-time enable. It adds standard/extended identifier support, bit stuffing, CRC-15 generation, bitwise arbitration with loss detection, ACK-slot checking and bus-idle integration. It sits between the node's message source and the transceiver pins. It is the bit-level engine that each node instance on the shared bus uses.

## Interface
- ID_WIDTH, 11: identifier width; 11 (standard) or 29 (extended); other values illegal.
- MAX_DLC, 8: maximum data bytes carried (1..8).
- IDLE_BITS, 11: consecutive recessive bits required before bus is considered idle.
- can_clk  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- bit_tick  in  1  one-cycle pulse per nominal bit time; all bit activity happens only on cycles with bit_tick=1.
- can_rx  in  1  sampled bus level (0 = dominant).
- can_tx  out  1  driven bus level (0 = dominant); registered.
- tx_req  in  1  level request to send; held until tx_accept.
- tx_id  in  ID_WIDTH  identifier.
- tx_dlc  in  4  DLC field value.
- tx_data  in  8*MAX_DLC  payload; byte 0 = bits [7:0], sent first, MSB first.
- tx_accept  out  1  one-cycle pulse when the request is latched.
- tx_done  out  1  one-cycle pulse after last EOF bit sent without error.
- arb_lost  out  1  one-cycle pulse on arbitration loss.
- tx_err  out  1  one-cycle pulse on bit error or missing ACK.
- busy  out  1  high from tx_accept until done/lost/err pulse.

## Operation
- States: INTEGRATE, IDLE, SEND, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, RECOVER.
- On reset: state=INTEGRATE, can_tx=1, all pulses 0, busy=0, counters 0.
- INTEGRATE/RECOVER: can_tx=1. Count consecutive ticks with can_rx=1; a dominant sample clears the count. When the count reaches IDLE_BITS, go to IDLE.
- IDLE: on a tick with tx_req=1 and can_rx=1, latch tx_id/tx_dlc/tx_data. Pulse tx_accept, set busy, drive SOF (0), and enter SEND.
- IDLE: a tick with can_rx=0 means a foreign SOF. Go to INTEGRATE; the request is not accepted and stays pending.
- Frame bit order, standard: SOF, ID[10:0], RTR=0, IDE=0, r0=0, DLC[3:0], data, CRC[14:0].
- Frame bit order, extended: SOF, ID[28:18], SRR=1, IDE=1, ID[17:0], RTR=0, r1=0, r0=0, DLC, data, CRC.
- Data bytes sent = min(tx_dlc, MAX_DLC). The DLC field is sent unmodified, including values 9..15.
- CRC-15: polynomial 0x4599, init 0. Computed over unstuffed bits SOF through last data bit.
- Stuffing: SOF through CRC[0]. After 5 consecutive equal bits (stuff bits included in the run), insert one complement bit. Stuff bits are excluded from CRC. A stuff bit due after CRC[0] is still inserted.
- Every SEND tick compares the sampled can_rx with the bit currently on can_tx.
  - Arbitration field (ID, SRR, IDE, RTR; non-stuff bits only): can_tx=1 and can_rx=0 → pulse arb_lost, can_tx=1, go to INTEGRATE.
  - Any other mismatch, including on stuff bits → pulse tx_err, go to RECOVER.
- CRC_DEL: send 1.
- ACK_SLOT: send 1; can_rx must sample 0, else pulse tx_err and go to RECOVER.
- ACK_DEL: send 1.
- EOF: 7 recessive bits. A dominant sample during CRC_DEL, ACK_DEL or EOF → tx_err, RECOVER.
- After the 7th EOF tick: pulse tx_done, clear busy, go to INTEGRATE (provides intermission).
- No error frames are generated; the error reaction is bus release only.

## Timing
- can_tx updates on the cycle of the tick edge and holds until the next tick. can_rx is sampled on the tick cycle against the bit driven since the previous tick.
- tx_accept is asserted on the same clock edge as the SOF appears on can_tx.
- tx_done, arb_lost and tx_err are asserted on the deciding tick edge. Exactly one of them ends each accepted frame. busy falls on the same edge.
- No bit_tick → no state change, pulse outputs stay 0.
- tx_req changes while busy are ignored. The latched frame is used until the end.
- Reset asserted mid-frame: can_tx=1 immediately (asynchronous); no done/err pulse.
- Standard, DLC=1, no stuffing: SOF at tick 0, last EOF bit at tick 51, tx_done on tick 52.

## Test plan
- ID=0x123, DLC=1, data 0x89, bus echoes can_tx with ACK forced 0 → unstuffed CRC, delimiters and EOF match the golden model; one tx_accept, one tx_done, busy low after.
- Node sends 0x456 while a bus model ANDs in a node sending 0x123 → arb_lost on the first ID tick (bit 10), can_tx=1 afterwards, no tx_err, re-send after 11 recessive bits.
- ID=0x000, DLC=0 → stuff bit 1 inserted after SOF plus 4 ID zeros; stream decoded by reference destuffer equals the unstuffed frame; CRC excludes stuff bits.
- Echo loop without ACK (ACK slot sampled 1) → tx_err pulse on ACK tick, RECOVER, no tx_done.
- DLC=15, MAX_DLC=8 → DLC field 1111, exactly 8 data bytes, tx_done.
- Reset low during data field → can_tx=1 same cycle; after release, frame restarts only after 11 recessive ticks.
